// File: rtl/vram_cpu_bridge.sv
// vram_cpu_bridge: single-outstanding CPU to video-chip access bridge.
// Accepts one 16-bit read, full write or byte-masked write at a time and
// sequences strobe / wait-for-busy / wait-for-idle phases on the chip side.
// Partial writes are done as read-modify-write. A stuck chip (busy never
// rising) is aborted after a short timeout and reported with cpu_err.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cpu_req/we/be/addr    request, write flag, byte enables, byte address
//   cpu_wdata             write data
//   cpu_ready             idle and chip not busy; request accepted now
//   cpu_ack/err/rdata     completion pulse, timeout flag, read word
//   mem_cs/rd/wr          one-cycle chip access strobes
//   mem_addr/dout         word address and write data to the chip
//   mem_din, mem_busy     read data and busy flag from the chip
module vram_cpu_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        cpu_err,
    output logic        mem_cs,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din,
    input  logic        mem_busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_STB,
        RD_WAIT,
        RD_DONE,
        WR_STB,
        WR_WAIT,
        WR_DONE,
        ACK
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic [2:0]  to_q, to_d;
    logic        err_q, err_d;

    logic [1:0]  be_in;
    logic [15:0] merged;

    // No enables at all means a plain 16-bit access.
    assign be_in = (cpu_be == 2'b00) ? 2'b11 : cpu_be;

    // Enabled bytes come from the CPU, the rest from the word just read.
    assign merged = {be_q[1] ? wdata_q[15:8] : mem_din[15:8],
                     be_q[0] ? wdata_q[7:0]  : mem_din[7:0]};

    assign cpu_ready = (state_q == IDLE) && !mem_busy;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req && cpu_ready) begin
                    addr_d  = {cpu_addr[15:1], 1'b0};
                    we_d    = cpu_we;
                    be_d    = be_in;
                    wdata_d = cpu_wdata;
                    dout_d  = cpu_wdata;
                    err_d   = 1'b0;
                    // Partial writes start with a read of the target word.
                    if (cpu_we && be_in == 2'b11) begin
                        state_d = WR_STB;
                    end else begin
                        state_d = RD_STB;
                    end
                end
            end
            RD_STB: begin
                to_d    = 3'd0;
                state_d = RD_WAIT;
            end
            WR_STB: begin
                to_d    = 3'd0;
                state_d = WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_busy) begin
                    state_d = (state_q == RD_WAIT) ? RD_DONE : WR_DONE;
                end else if (to_q == 3'd6) begin
                    // Seventh idle wait cycle: the chip never took it.
                    to_d    = 3'd7;
                    err_d   = 1'b1;
                    rdata_d = 16'hFFFF;
                    state_d = ACK;
                end else begin
                    to_d = to_q + 3'd1;
                end
            end
            RD_DONE: begin
                if (!mem_busy) begin
                    rdata_d = mem_din;
                    if (we_q) begin
                        dout_d  = merged;
                        state_d = WR_STB;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WR_DONE: begin
                if (!mem_busy) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
            addr_q  <= 16'h0000;
            dout_q  <= 16'h0000;
            rdata_q <= 16'h0000;
            to_q    <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign mem_cs    = (state_q == RD_STB) || (state_q == WR_STB);
    assign mem_rd    = (state_q == RD_STB);
    assign mem_wr    = (state_q == WR_STB);
    assign mem_addr  = addr_q;
    assign mem_dout  = dout_q;
    assign cpu_ack   = (state_q == ACK);
    assign cpu_err   = (state_q == ACK) && err_q;
    assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_vram_cpu_bridge.sv
// tb_vram_cpu_bridge: directed bench for vram_cpu_bridge with a simple
// video-chip model and a transaction-level reference checked every cycle.
module tb_vram_cpu_bridge;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_cs;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din;
    logic        mem_busy;

    bit chip_busy;
    bit force_busy;
    assign mem_busy = chip_busy | force_busy;

    vram_cpu_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .mem_cs    (mem_cs),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_busy  (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Video-chip model: busy rises one cycle after a strobe, stays high
    // blen cycles, read data appears as busy falls.
    logic [15:0] chip_mem [int];
    int          blen = 1;
    bit          chip_dead = 0;
    bit          pend = 0;
    bit          was_rd = 0;
    int          cnt = 0;
    logic [15:0] ca = 16'h0;

    function automatic logic [15:0] chip_rd(input logic [15:0] a);
        return chip_mem.exists(int'(a)) ? chip_mem[int'(a)] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
            chip_busy = 0;
            cnt = 0;
        end else begin
            if (chip_busy) begin
                cnt--;
                if (cnt == 0) begin
                    chip_busy = 0;
                    if (was_rd) mem_din = chip_rd(ca);
                end
            end else if (pend) begin
                pend = 0;
                chip_busy = 1;
                cnt = blen;
                mem_din = 16'hDEAD;
            end
            if (mem_cs && (mem_rd || mem_wr) && !chip_dead) begin
                pend = 1;
                ca = mem_addr;
                was_rd = mem_rd;
                if (mem_wr) chip_mem[int'(mem_addr)] = mem_dout;
            end
        end
    end

    // Reference: memory image plus per-transaction expectations.
    logic [15:0] ref_mem [int];
    logic [15:0] model_rdata = 16'h0;
    int          e_ack = 0;
    int          e_wr_cyc = 0;
    logic [15:0] e_addr = 16'h0;
    logic [15:0] e_dout = 16'h0;
    logic [15:0] e_rdata = 16'h0;
    bit          e_err = 0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    bit          go = 0;
    bit          active = 0;
    bit          done = 0;
    int          cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [2:0]  exp_str;
    bit          at_ack;
    logic [15:0] last_rd_addr = 16'h0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [15:0] last_wr_dout = 16'h0;
    logic [15:0] last_ack_rdata = 16'h0;
    bit          last_ack_err = 0;
    int          last_ack_cyc = 0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            active = 0;
            go = 0;
        end else begin
            if (go) begin
                active = 1;
                cyc = 1;
                go = 0;
                n_rd = 0;
                n_wr = 0;
            end else if (active) begin
                cyc++;
            end
            exp_str = 3'b000;
            if (active && cyc == 1)
                exp_str = (e_wr_cyc == 1) ? 3'b101 : 3'b110;
            else if (active && e_wr_cyc > 1 && cyc == e_wr_cyc)
                exp_str = 3'b101;
            chk("strobes", 32'({mem_cs, mem_rd, mem_wr}), 32'(exp_str));
            at_ack = active && (cyc == e_ack);
            chk("cpu_ack", 32'(cpu_ack), 32'(at_ack));
            chk("cpu_err", 32'(cpu_err), 32'(at_ack && e_err));
            if (mem_rd) begin
                n_rd++;
                last_rd_addr = mem_addr;
            end
            if (mem_wr) begin
                n_wr++;
                last_wr_addr = mem_addr;
                last_wr_dout = mem_dout;
            end
            if (active && (mem_cs || mem_busy))
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (active && e_wr_cyc > 0 && cyc >= e_wr_cyc && cyc < e_ack
                && (mem_wr || mem_busy))
                chk("mem_dout", 32'(mem_dout), 32'(e_dout));
            if (at_ack) begin
                chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
                last_ack_rdata = cpu_rdata;
                last_ack_err = cpu_err;
                last_ack_cyc = cyc;
                active = 0;
                done = 1;
            end
        end
    end

    bit hold_q = 0;

    task automatic start_txn(input logic we, input logic [1:0] be,
                             input logic [15:0] addr,
                             input logic [15:0] wdata,
                             input int b, input bit dead, input bit hold);
        logic [15:0] wa;
        logic [1:0]  bee;
        logic [15:0] old;
        logic [15:0] nw;
        wa  = {addr[15:1], 1'b0};
        bee = (be == 2'b00) ? 2'b11 : be;
        old = ref_rd(wa);
        @(negedge clk);
        #1;
        for (int i = 0; i < 50 && !cpu_ready; i++) begin
            @(negedge clk);
            #1;
        end
        chk("ready_before_req", 32'(cpu_ready), 32'd1);
        blen = b;
        chip_dead = dead;
        e_addr = wa;
        e_err = 0;
        e_wr_cyc = 0;
        if (dead) begin
            e_ack = 9;
            e_err = 1;
            e_rdata = 16'hFFFF;
        end else if (!we) begin
            e_ack = 3 + b;
            e_rdata = old;
        end else if (bee == 2'b11) begin
            e_ack = 3 + b;
            e_wr_cyc = 1;
            e_dout = wdata;
            e_rdata = model_rdata;
            ref_mem[int'(wa)] = wdata;
        end else begin
            nw[15:8] = bee[1] ? wdata[15:8] : old[15:8];
            nw[7:0]  = bee[0] ? wdata[7:0] : old[7:0];
            e_ack = 5 + 2 * b;
            e_wr_cyc = 3 + b;
            e_dout = nw;
            e_rdata = old;
            ref_mem[int'(wa)] = nw;
        end
        model_rdata = e_rdata;
        done = 0;
        hold_q = hold;
        cpu_req = 1;
        cpu_we = we;
        cpu_be = be;
        cpu_addr = addr;
        cpu_wdata = wdata;
        go = 1;
        @(posedge clk);
        #2;
        if (!hold) cpu_req = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && !done; i++) begin
            @(posedge clk);
            #2;
        end
        chk("ack_seen", 32'(done), 32'd1);
        if (hold_q) begin
            chk("ready_in_ack", 32'(cpu_ready), 32'd0);
            @(posedge clk);
            #2;
            cpu_req = 0;
        end
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_strobes"}, 32'({mem_cs, mem_rd, mem_wr}), 32'd0);
        chk({tag, "_ack"}, 32'(cpu_ack), 32'd0);
        chk({tag, "_err"}, 32'(cpu_err), 32'd0);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_dout"}, 32'(mem_dout), 32'd0);
    endtask

    initial begin
        reset = 0;
        cpu_req = 0;
        cpu_we = 0;
        cpu_be = 2'b11;
        cpu_addr = 16'h0;
        cpu_wdata = 16'h0;
        mem_din = 16'h0;
        force_busy = 0;
        chip_mem[16'h4002] = 16'hBEEF;
        chip_mem[16'h0020] = 16'h5566;
        ref_mem[16'h4002] = 16'hBEEF;
        ref_mem[16'h0020] = 16'h5566;
        #2 reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_checks("reset");
        chk("reset_ready", 32'(cpu_ready), 32'd1);
        reset = 0;

        start_txn(1'b0, 2'b11, 16'h4002, 16'h0000, 6, 0, 0);
        wait_done();
        chk("rd_lit_addr", 32'(last_rd_addr), 32'h4002);
        chk("rd_lit_data", 32'(last_ack_rdata), 32'hBEEF);
        chk("rd_lit_err", 32'(last_ack_err), 32'd0);
        chk("rd_lit_lat", 32'(last_ack_cyc), 32'd9);
        chk("rd_lit_nrd", 32'(n_rd), 32'd1);

        start_txn(1'b1, 2'b11, 16'h0011, 16'h1234, 3, 0, 0);
        wait_done();
        chk("fw_lit_addr", 32'(last_wr_addr), 32'h0010);
        chk("fw_lit_dout", 32'(last_wr_dout), 32'h1234);
        chk("fw_lit_rdata", 32'(last_ack_rdata), 32'hBEEF);
        chk("fw_lit_nrd", 32'(n_rd), 32'd0);
        chk("fw_lit_nwr", 32'(n_wr), 32'd1);

        start_txn(1'b1, 2'b10, 16'h0020, 16'hAB00, 2, 0, 0);
        wait_done();
        chk("pw_lit_dout", 32'(last_wr_dout), 32'hAB66);
        chk("pw_lit_rdata", 32'(last_ack_rdata), 32'h5566);
        chk("pw_lit_nrd", 32'(n_rd), 32'd1);
        chk("pw_lit_nwr", 32'(n_wr), 32'd1);
        chk("pw_lit_lat", 32'(last_ack_cyc), 32'd9);

        start_txn(1'b0, 2'b11, 16'h0020, 16'h0000, 1, 0, 0);
        wait_done();
        start_txn(1'b1, 2'b01, 16'h0021, 16'h00CD, 4, 0, 0);
        wait_done();
        start_txn(1'b0, 2'b00, 16'h0021, 16'h0000, 2, 0, 0);
        wait_done();
        chk("pw2_lit_data", 32'(last_ack_rdata), 32'hABCD);

        start_txn(1'b1, 2'b00, 16'h0030, 16'h7788, 2, 0, 0);
        wait_done();
        start_txn(1'b0, 2'b11, 16'h0030, 16'h0000, 3, 0, 1);
        wait_done();
        chk("be00_lit_data", 32'(last_ack_rdata), 32'h7788);

        start_txn(1'b0, 2'b11, 16'h0040, 16'h0000, 1, 1, 0);
        wait_done();
        chk("to_lit_data", 32'(last_ack_rdata), 32'hFFFF);
        chk("to_lit_err", 32'(last_ack_err), 32'd1);
        chk("to_lit_lat", 32'(last_ack_cyc), 32'd9);
        chk("to_lit_nrd", 32'(n_rd), 32'd1);
        start_txn(1'b0, 2'b11, 16'h0011, 16'h0000, 2, 0, 0);
        wait_done();
        chk("after_to_data", 32'(last_ack_rdata), 32'h1234);

        @(negedge clk);
        #1;
        force_busy = 1;
        cpu_req = 1;
        cpu_we = 0;
        cpu_addr = 16'h4002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("ready_busy", 32'(cpu_ready), 32'd0);
        end
        cpu_req = 0;
        force_busy = 0;
        start_txn(1'b0, 2'b11, 16'h4002, 16'h0000, 2, 0, 0);
        wait_done();
        chk("stall_lit_data", 32'(last_ack_rdata), 32'hBEEF);

        start_txn(1'b0, 2'b11, 16'h0040, 16'h5A5A, 1, 1, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1;
        #1 rst_checks("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_rdata = 16'h0;
        chip_dead = 0;
        repeat (4) @(posedge clk);
        start_txn(1'b1, 2'b11, 16'h0050, 16'h0F0F, 2, 0, 0);
        wait_done();
        chk("rst_lit_rdata", 32'(last_ack_rdata), 32'h0000);
        start_txn(1'b0, 2'b11, 16'h4002, 16'h0000, 2, 0, 0);
        wait_done();
        chk("rst_lit_data", 32'(last_ack_rdata), 32'hBEEF);

        repeat (3) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
